// File: rtl/feeder_pkg.sv
// Shared types and constants for the instruction stream feeder.
package feeder_pkg;

  // Serving FSM: wait for start, accept a request, count latency, respond.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Addressing mode latched on start.
  typedef enum logic {
    STREAM  = 1'b0,
    INDEXED = 1'b1
  } mode_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  // Largest response latency the 3-bit counter can hold.
  localparam int LATENCY_MAX = 7;

endpackage

// File: rtl/instr_stream_feeder_if.sv
// Instruction-memory port between a core (master) and the feeder (slave).
//
// Handshake: the master raises imem_read with pc; a request is accepted on the
// first rising edge where the feeder is ready. The feeder answers with a
// single-cycle imem_resp strobe, and instr is valid only while imem_resp=1.
// There is no back-pressure on the response; the master must take it.
interface instr_stream_feeder_if;
  logic [31:0] pc;
  logic        imem_read;
  logic [31:0] instr;
  logic        imem_resp;

  modport master (output pc, imem_read, input instr, imem_resp);
  modport slave  (input pc, imem_read, output instr, imem_resp);
endinterface

// File: rtl/feeder_prog_mem.sv
// Program buffer: one synchronous write port, one asynchronous read port.
// A read of an index written in the same cycle returns the old word.
module feeder_prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_stream_feeder.sv
// Answers a core's instruction fetches from a loadable program buffer, either
// as a sequential stream or indexed by PC, with a fixed response latency.
module instr_stream_feeder
  import feeder_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter int          AW        = $clog2(DEPTH),
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD  = NOP_WORD_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_en,
  input  logic [AW-1:0]        load_addr,
  input  logic [31:0]          load_data,
  input  logic [AW:0]          prog_len,
  input  logic                 mode,
  input  logic                 start,
  instr_stream_feeder_if.slave imem,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [AW:0]          issued_count,
  output state_t               dbg_state
);

  localparam logic [AW:0] ONE      = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [2:0]  LAT_INIT = 3'(LATENCY - 1);

  state_t      state_q;
  mode_t       mode_q;
  logic [2:0]  cnt_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        resp_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [AW:0] issued_q;
  logic [AW:0] ptr_q;
  logic [AW:0] len_q;

  logic [31:0]   req_pc;
  logic [29:0]   widx;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rdata;
  logic          fire;
  logic          hit;
  logic          set_done;
  logic          set_err;

  feeder_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (load_en),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (rd_idx),
    .rdata (rdata)
  );

  // Decide the response word and flag updates for the request being answered.
  // With LATENCY=1 the response is formed on the accept edge, so pc is used
  // directly; otherwise the PC captured at accept is used.
  always_comb begin
    req_pc   = (state_q == READY) ? imem.pc : pc_q;
    widx     = 30'((req_pc - BASE_ADDR) >> 2);
    rd_idx   = '0;
    hit      = 1'b0;
    set_done = 1'b0;
    set_err  = 1'b0;
    fire     = ((state_q == READY) && imem.imem_read && (LATENCY == 1)) ||
               ((state_q == WAIT) && (cnt_q == 3'd1));
    if (mode_q == STREAM) begin
      rd_idx   = ptr_q[AW-1:0];
      hit      = (ptr_q < len_q);
      set_done = !hit || ((ptr_q + ONE) == len_q);
    end else begin
      // Range check on the full word offset before truncating to AW bits.
      rd_idx = widx[AW-1:0];
      if (req_pc[1:0] != 2'b00) begin
        set_err = 1'b1;
      end else if (done_q || ({2'b00, widx} >= 32'(len_q))) begin
        set_done = 1'b1;
      end else begin
        hit = 1'b1;
      end
    end
  end

  // Serving FSM with registered response and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= STREAM;
      cnt_q    <= 3'd0;
      pc_q     <= 32'd0;
      instr_q  <= NOP_WORD;
      resp_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      issued_q <= '0;
      ptr_q    <= '0;
      len_q    <= '0;
    end else begin
      resp_q <= 1'b0;
      if (start) begin
        // Start (or restart): abandon any pending request without a response.
        state_q  <= READY;
        mode_q   <= mode ? INDEXED : STREAM;
        len_q    <= prog_len;
        cnt_q    <= 3'd0;
        busy_q   <= 1'b1;
        done_q   <= 1'b0;
        err_q    <= 1'b0;
        issued_q <= '0;
        ptr_q    <= '0;
      end else begin
        case (state_q)
          IDLE: state_q <= IDLE;
          READY: begin
            if (imem.imem_read) begin
              pc_q <= imem.pc;
              if (LATENCY == 1) begin
                state_q <= RESP;
              end else begin
                cnt_q   <= LAT_INIT;
                state_q <= WAIT;
              end
            end
          end
          WAIT: begin
            if (cnt_q == 3'd1) state_q <= RESP;
            else               cnt_q   <= cnt_q - 3'd1;
          end
          RESP: state_q <= READY;
          default: state_q <= IDLE;
        endcase

        if (fire) begin
          resp_q  <= 1'b1;
          instr_q <= hit ? rdata : NOP_WORD;
          if (hit) begin
            if (mode_q == STREAM) ptr_q <= ptr_q + ONE;
            if (issued_q != DEPTH_W) issued_q <= issued_q + ONE;
          end
          if (set_done) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
          if (set_err) err_q <= 1'b1;
        end
      end
    end
  end

  assign imem.instr     = instr_q;
  assign imem.imem_resp = resp_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign issued_count   = issued_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_instr_stream_feeder.sv
// Directed-plus-random bench for instr_stream_feeder. Two instances share all
// stimulus: one with LATENCY=1, one with LATENCY=4; sel picks the one checked.
module tb_instr_stream_feeder;
  import feeder_pkg::*;

  localparam int          DEPTH = 16;
  localparam int          AW    = 4;
  localparam logic [31:0] BASE  = 32'h6000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic [AW:0]   prog_len;
  logic          mode;
  logic          start;
  logic [31:0]   pc_d;
  logic          rd_d;
  bit            sel;

  instr_stream_feeder_if if1 ();
  instr_stream_feeder_if if4 ();
  assign if1.pc = pc_d;
  assign if1.imem_read = rd_d;
  assign if4.pc = pc_d;
  assign if4.imem_read = rd_d;

  logic        busy1, done1, err1, busy4, done4, err4;
  logic [AW:0] iss1, iss4;
  state_t      st1, st4;

  instr_stream_feeder #(.DEPTH(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) dut1 (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .mode(mode), .start(start),
    .imem(if1), .busy(busy1), .done(done1), .err(err1),
    .issued_count(iss1), .dbg_state(st1)
  );

  instr_stream_feeder #(.DEPTH(DEPTH), .LATENCY(4), .BASE_ADDR(BASE)) dut4 (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .mode(mode), .start(start),
    .imem(if4), .busy(busy4), .done(done4), .err(err4),
    .issued_count(iss4), .dbg_state(st4)
  );

  logic        resp_o, busy_o, done_o, err_o;
  logic [31:0] instr_o;
  logic [AW:0] iss_o;
  state_t      st_o;
  assign resp_o  = sel ? if4.imem_resp : if1.imem_resp;
  assign instr_o = sel ? if4.instr : if1.instr;
  assign busy_o  = sel ? busy4 : busy1;
  assign done_o  = sel ? done4 : done1;
  assign err_o   = sel ? err4 : err1;
  assign iss_o   = sel ? iss4 : iss1;
  assign st_o    = sel ? st4 : st1;

  // Reference model: program image plus the stream/indexed rules.
  logic [31:0] mem_m [DEPTH];
  int          m_ptr, m_len, m_issued;
  bit          m_done, m_err, m_idx;

  // Scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_resp(input logic [31:0] p, output logic [31:0] w);
    int oi;
    w = NOP;
    if (!m_idx) begin
      if (m_ptr < m_len) begin
        w = mem_m[m_ptr];
        m_ptr++;
        if (m_issued < DEPTH) m_issued++;
        if (m_ptr == m_len) m_done = 1'b1;
      end else begin
        m_done = 1'b1;
      end
    end else begin
      oi = int'((p - BASE) >> 2);
      if (p[1:0] != 2'b00) begin
        m_err = 1'b1;
      end else if (m_done || oi >= m_len) begin
        m_done = 1'b1;
      end else begin
        w = mem_m[oi];
        if (m_issued < DEPTH) m_issued++;
      end
    end
  endtask

  // Driver tasks
  task automatic do_load(input int a, input logic [31:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = AW'(a); load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic do_start(input int len, input bit idx);
    @(negedge clk);
    start = 1'b1; prog_len = (AW+1)'(len); mode = idx;
    @(negedge clk);
    start = 1'b0;
    m_ptr = 0; m_len = len; m_issued = 0; m_done = 1'b0; m_err = 1'b0; m_idx = idx;
    chk("start_busy", busy_o, 1);
    chk("start_issued", iss_o, 0);
  endtask

  // One request: exp_n edges from raising imem_read until imem_resp is seen.
  task automatic request(input string tag, input logic [31:0] p, input int exp_n,
                         input bit hold, input bit drop, input bit ld,
                         input logic [31:0] ld_d);
    logic [31:0] w;
    int n;
    bit got;
    model_resp(p, w);
    @(negedge clk);
    pc_d = p; rd_d = 1'b1;
    if (ld) begin load_en = 1'b1; load_addr = '0; load_data = ld_d; end
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      load_en = 1'b0;
      if (drop && n == 1) rd_d = 1'b0;
      if (resp_o) got = 1'b1;
    end
    if (ld) mem_m[0] = ld_d;
    chk({tag, "_resp"}, got, 1);
    chk({tag, "_lat"}, n, exp_n);
    chk({tag, "_instr"}, instr_o, w);
    chk({tag, "_done"}, done_o, m_done);
    chk({tag, "_err"}, err_o, m_err);
    chk({tag, "_issued"}, iss_o, m_issued);
    chk({tag, "_busy"}, busy_o, !m_done);
    if (!hold) begin
      @(negedge clk);
      rd_d = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_one_cycle"}, resp_o, 0);
    end
  endtask

  // Directed sequence
  initial begin
    int len;
    bit orphan;
    logic [31:0] newv;
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    prog_len = '0; mode = 1'b0; start = 1'b0; pc_d = '0; rd_d = 1'b0; sel = 1'b0;
    m_ptr = 0; m_len = 0; m_issued = 0; m_done = 0; m_err = 0; m_idx = 0;

    // Reset values on both instances
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_resp", resp_o, 0);
      chk("rst_instr", instr_o, NOP);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_issued", iss_o, 0);
      chk("rst_state", st_o, IDLE);
    end
    @(negedge clk);
    rst = 1'b0;

    // Stream, LATENCY=1: nine addi words, imem_read held, then the NOP tail
    sel = 1'b0;
    for (int k = 0; k < 9; k++)
      do_load(k, ((32'h0F + 32'hFE * k) << 20) | ((k + 1) << 7) | 32'h13);
    do_start(9, 1'b0);
    for (int k = 0; k < 9; k++)
      request("s1", 32'd0, (k == 0) ? 1 : 2, 1'b1, 1'b0, 1'b0, 32'd0);
    request("s1_tail", 32'd0, 2, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("s1_tail_word", instr_o, NOP);

    // Stream, LATENCY=4 with random program; imem_read dropped during WAIT once
    sel = 1'b1;
    for (int k = 0; k < 8; k++) do_load(k, $urandom);
    len = $urandom_range(3, 6);
    do_start(len, 1'b0);
    for (int k = 0; k <= len; k++)
      request("s4", 32'd0, 4, 1'b0, (k == 1), 1'b0, 32'd0);

    // Restart mid-stream after three words
    sel = 1'b0;
    do_start(8, 1'b0);
    for (int k = 0; k < 3; k++) request("pre", 32'd0, 1, 1'b0, 1'b0, 1'b0, 32'd0);
    do_start(8, 1'b0);
    request("restart", 32'd0, 1, 1'b0, 1'b0, 1'b0, 32'd0);

    // Load to index 0 in the same cycle as its fetch: old word, then new word
    newv = $urandom;
    do_start(2, 1'b0);
    request("ldcol", 32'd0, 1, 1'b0, 1'b0, 1'b1, newv);
    do_start(2, 1'b0);
    request("ldnew", 32'd0, 1, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("ldnew_word", instr_o, newv);

    // Indexed mode
    do_start(4, 1'b1);
    request("ix_rand", BASE + 32'(4 * $urandom_range(0, 3)), 1, 1'b0, 1'b0, 1'b0, 32'd0);
    request("ix_two", BASE + 32'h8, 1, 1'b0, 1'b0, 1'b0, 32'd0);
    request("ix_misal", BASE + 32'h2, 1, 1'b0, 1'b0, 1'b0, 32'd0);
    request("ix_range", BASE + 32'h10, 1, 1'b0, 1'b0, 1'b0, 32'd0);
    request("ix_after", BASE + 32'h4, 1, 1'b0, 1'b0, 1'b0, 32'd0);

    // Reset during WAIT on the LATENCY=4 instance
    sel = 1'b1;
    do_start(3, 1'b0);
    @(negedge clk);
    rd_d = 1'b1; pc_d = '0;
    @(posedge clk); #1;
    chk("rw_wait_state", st_o, WAIT);
    @(negedge clk);
    rd_d = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("rw_resp", resp_o, 0);
    chk("rw_instr", instr_o, NOP);
    chk("rw_busy", busy_o, 0);
    chk("rw_done", done_o, 0);
    chk("rw_issued", iss_o, 0);
    chk("rw_state", st_o, IDLE);
    @(negedge clk);
    rst = 1'b0;
    orphan = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp_o) orphan = 1'b1;
    end
    chk("rw_no_orphan", orphan, 0);
    do_start(3, 1'b0);
    request("rw_restart", 32'd0, 4, 1'b0, 1'b0, 1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
